// File: rtl/jtgng_rom_sched.sv
// jtgng_rom_sched: one SDRAM read port shared among CH ROM clients.
// A programmable 16-entry slot table picks, on every cen, which channel gets
// the port, or whether a refresh goes out instead. Read data comes back LAT
// cen cycles after the address and is routed to the owning channel. ch_ok
// marks data that still matches the address the client is presenting.
// Ports:
//   clk_i, rst_i      system clock, synchronous active-high reset
//   cen_i             slot-advance enable
//   sync_i            restarts slot numbering at 0 (only together with cen_i)
//   downloading_i     ROM download in progress; holds the block in reset
//   ch_addr_i         per-channel address, CH x (AW+1)
//   ch_dout_o         per-channel read data, CH x 16
//   ch_ok_o           per-channel data-matches-address flag
//   ready_o           scheduler running and pipeline primed
//   autorefresh_o     refresh request to the SDRAM controller
//   sdram_addr_o      read word address to the SDRAM controller
//   data_read_i       SDRAM read data
module jtgng_rom_sched #(
   parameter int unsigned      CH        = 4,
   parameter int unsigned      AW        = 22,
   parameter int unsigned      LAT       = 1,
   parameter logic [CH*AW-1:0] OFFSETS   = '0,
   parameter logic [CH-1:0]    BYTE_MASK = '0,
   parameter logic [63:0]      SLOT_MAP  = 64'hE000_0000_3210_3210
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cen_i,
   input  logic                   sync_i,
   input  logic                   downloading_i,
   input  logic [CH*(AW+1)-1:0]   ch_addr_i,
   output logic [CH*16-1:0]       ch_dout_o,
   output logic [CH-1:0]          ch_ok_o,
   output logic                   ready_o,
   output logic                   autorefresh_o,
   output logic [AW-1:0]          sdram_addr_o,
   input  logic [15:0]            data_read_i
);

   localparam int unsigned KW = AW + 1;

   logic [3:0]    slot_q;
   logic [AW-1:0] sdram_addr_q;
   logic          autorefresh_q;
   logic [3:0]    rdy_sh_q;
   logic          ready_q;
   logic [CH-1:0] ok_q;
   logic [15:0]   dout_q [CH];
   logic [AW:0]   last_q [CH];   // address key of the last capture per channel

   // Read pipeline; index LAT-1 is the entry whose data arrives this cen
   logic          pv_q   [LAT];
   logic [3:0]    pch_q  [LAT];
   logic [AW:0]   pkey_q [LAT];

   logic [3:0]    entry;
   logic [AW:0]   cur_key [CH];  // comparable address: word channels drop bit AW
   logic [AW-1:0] waddr   [CH];
   logic          issue_hit;
   logic [AW-1:0] issue_addr;
   logic [AW:0]   issue_key;
   logic [CH-1:0] cap_hit;
   logic [15:0]   cap_data [CH];
   logic [AW:0]   cap_key;

   assign entry   = SLOT_MAP[{slot_q, 2'b00} +: 4];
   assign cap_key = pkey_q[LAT-1];

   always_comb begin
      issue_hit  = 1'b0;
      issue_addr = '0;
      issue_key  = '0;
      for (int c = 0; c < CH; c++) begin
         if (BYTE_MASK[c]) begin
            cur_key[c] = ch_addr_i[c*KW +: KW];
            waddr[c]   = ch_addr_i[c*KW+1 +: AW];
         end else begin
            cur_key[c] = {1'b0, ch_addr_i[c*KW +: AW]};
            waddr[c]   = ch_addr_i[c*KW +: AW];
         end
         if (entry == 4'(c)) begin
            issue_hit  = 1'b1;
            issue_addr = OFFSETS[c*AW +: AW] + waddr[c];
            issue_key  = cur_key[c];
         end
         cap_hit[c] = cen_i && pv_q[LAT-1] && (pch_q[LAT-1] == 4'(c));
         if (BYTE_MASK[c]) begin
            cap_data[c] = {8'd0, cap_key[0] ? data_read_i[7:0] : data_read_i[15:8]};
         end else begin
            cap_data[c] = data_read_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || downloading_i) begin
         slot_q        <= '0;
         sdram_addr_q  <= '0;
         autorefresh_q <= 1'b0;
         rdy_sh_q      <= '0;
         ready_q       <= 1'b0;
         ok_q          <= '0;
         for (int c = 0; c < CH; c++) begin
            dout_q[c] <= '0;
            last_q[c] <= '0;
         end
         for (int i = 0; i < LAT; i++) begin
            pv_q[i]   <= 1'b0;
            pch_q[i]  <= '0;
            pkey_q[i] <= '0;
         end
      end else begin
         rdy_sh_q <= {rdy_sh_q[2:0], 1'b1};
         ready_q  <= rdy_sh_q[3];
         if (cen_i) begin
            slot_q        <= sync_i ? 4'd0 : slot_q + 4'd1;
            autorefresh_q <= (entry == 4'hE);
            if (issue_hit) sdram_addr_q <= issue_addr;
            pv_q[0]   <= issue_hit;
            pch_q[0]  <= entry;
            pkey_q[0] <= issue_key;
            for (int i = 1; i < LAT; i++) begin
               pv_q[i]   <= pv_q[i-1];
               pch_q[i]  <= pch_q[i-1];
               pkey_q[i] <= pkey_q[i-1];
            end
         end
         for (int c = 0; c < CH; c++) begin
            // A capture takes priority over the address-changed clear
            if (cap_hit[c]) begin
               dout_q[c] <= cap_data[c];
               ok_q[c]   <= (cap_key == cur_key[c]);
               last_q[c] <= cap_key;
            end else if (cur_key[c] != last_q[c]) begin
               ok_q[c] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      for (int c = 0; c < CH; c++) ch_dout_o[c*16 +: 16] = dout_q[c];
   end

   assign ch_ok_o       = ok_q;
   assign ready_o       = ready_q;
   assign autorefresh_o = autorefresh_q;
   assign sdram_addr_o  = sdram_addr_q;

endmodule

// File: tb/tb_jtgng_rom_sched.sv
// Bench for jtgng_rom_sched: directed opening checks, a free-run refresh
// count, then randomized traffic scored against a transaction-level model.
module tb_jtgng_rom_sched;

   localparam int unsigned CH  = 4;
   localparam int unsigned AW  = 22;
   localparam int unsigned LAT = 1;
   localparam int unsigned KW  = AW + 1;
   localparam logic [CH*AW-1:0] OFFS  = {22'h0, 22'h3FFFF0, 22'h01000, 22'h0A000};
   localparam logic [CH-1:0]    BMASK = 4'b1010;
   localparam logic [63:0]      SMAP  = 64'hE000_0000_3210_3210;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                cen = 1'b0;
   logic                sync = 1'b0;
   logic                dl = 1'b0;
   logic [CH*KW-1:0]    ch_addr = '0;
   logic [CH*16-1:0]    ch_dout;
   logic [CH-1:0]       ch_ok;
   logic                ready;
   logic                autorefresh;
   logic [AW-1:0]       sdram_addr;
   logic [15:0]         data_read = '0;

   int checks = 0;
   int errors = 0;

   jtgng_rom_sched #(
      .CH(CH), .AW(AW), .LAT(LAT), .OFFSETS(OFFS), .BYTE_MASK(BMASK), .SLOT_MAP(SMAP)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cen_i         (cen),
      .sync_i        (sync),
      .downloading_i (dl),
      .ch_addr_i     (ch_addr),
      .ch_dout_o     (ch_dout),
      .ch_ok_o       (ch_ok),
      .ready_o       (ready),
      .autorefresh_o (autorefresh),
      .sdram_addr_o  (sdram_addr),
      .data_read_i   (data_read)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          ch;
      logic [AW:0] key;
      int          due;
   } rd_t;

   typedef struct {
      logic [AW-1:0]    addr;
      logic             refr;
      logic             rdy;
      logic [CH*16-1:0] dout;
      logic [CH-1:0]    ok;
   } exp_t;

   rd_t          inflight[$];
   exp_t         exp_q[$];
   int           m_slot, m_cen_n, m_rdycnt;
   logic [15:0]  m_dout [CH];
   logic [AW:0]  m_last [CH];
   logic [CH-1:0] m_ok;
   logic [AW-1:0] m_addr;
   logic         m_ref;
   bit           seen_rst = 0;

   function automatic logic [KW-1:0] raw_addr(input int c);
      return ch_addr[c*KW +: KW];
   endfunction

   function automatic logic [AW:0] keyof(input int c);
      logic [KW-1:0] a;
      a = raw_addr(c);
      return BMASK[c] ? a : {1'b0, a[AW-1:0]};
   endfunction

   always @(posedge clk) begin
      bit   captured [CH];
      exp_t e;
      logic [63:0] sm;
      logic [3:0] ent;
      for (int c = 0; c < CH; c++) captured[c] = 0;
      if (rst || dl) begin
         seen_rst = 1;
         inflight.delete();
         m_slot = 0; m_cen_n = 0; m_rdycnt = 0;
         m_ok = '0; m_addr = '0; m_ref = 0;
         for (int c = 0; c < CH; c++) begin m_dout[c] = '0; m_last[c] = '0; end
      end else begin
         if (m_rdycnt < 5) m_rdycnt++;
         if (cen) begin
            m_cen_n++;
            while (inflight.size() > 0 && inflight[0].due == m_cen_n) begin
               rd_t r;
               r = inflight.pop_front();
               if (BMASK[r.ch]) m_dout[r.ch] = {8'd0, r.key[0] ? data_read[7:0] : data_read[15:8]};
               else             m_dout[r.ch] = data_read;
               m_ok[r.ch]   = (r.key == keyof(r.ch));
               m_last[r.ch] = r.key;
               captured[r.ch] = 1;
            end
            sm  = SMAP;
            ent = sm[m_slot*4 +: 4];
            if (int'(ent) < CH) begin
               logic [KW-1:0] a;
               logic [AW-1:0] w, o;
               rd_t nr;
               a = raw_addr(int'(ent));
               w = BMASK[ent] ? a[AW:1] : a[AW-1:0];
               o = OFFS[int'(ent)*AW +: AW];
               m_addr = o + w;
               m_ref  = 0;
               nr.ch = int'(ent); nr.key = keyof(int'(ent)); nr.due = m_cen_n + LAT;
               inflight.push_back(nr);
            end else begin
               m_ref = (ent == 4'hE);
            end
            m_slot = sync ? 0 : (m_slot + 1) % 16;
         end
         for (int c = 0; c < CH; c++)
            if (!captured[c] && keyof(c) != m_last[c]) m_ok[c] = 0;
      end
      if (seen_rst) begin
         e.addr = m_addr; e.refr = m_ref; e.rdy = (m_rdycnt >= 5); e.ok = m_ok;
         for (int c = 0; c < CH; c++) e.dout[c*16 +: 16] = m_dout[c];
         exp_q.push_back(e);
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sdram_addr", 64'(sdram_addr), 64'(e.addr));
            chk("autorefresh", 64'(autorefresh), 64'(e.refr));
            chk("ready", 64'(ready), 64'(e.rdy));
            chk("ch_ok", 64'(ch_ok), 64'(e.ok));
            for (int c = 0; c < CH; c++)
               chk($sformatf("ch_dout%0d", c), 64'(ch_dout[c*16 +: 16]), 64'(e.dout[c*16 +: 16]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int refr_cnt;
      rst = 1;
      repeat (3) step();
      chk("rst_sdram_addr", 64'(sdram_addr), 64'h0);
      chk("rst_ok", 64'(ch_ok), 64'h0);
      chk("rst_ready", 64'(ready), 64'h0);
      chk("rst_dout", 64'(ch_dout), 64'h0);
      rst = 0;
      ch_addr[0*KW +: KW] = 23'h00100;
      repeat (5) step();
      chk("ready_after_5", 64'(ready), 64'h1);
      // slot 0 issues channel 0
      cen = 1; data_read = 16'h1111;
      step();
      chk("first_addr", 64'(sdram_addr), 64'h0A100);
      data_read = 16'hBEEF;
      step();
      chk("beef_dout", 64'(ch_dout[15:0]), 64'hBEEF);
      chk("beef_ok", 64'(ch_ok[0]), 64'h1);
      // realign, then free-run 32 cen and count refresh cycles
      sync = 1;
      step();
      sync = 0;
      refr_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (autorefresh) refr_cnt++;
      end
      chk("refresh_pulses", 64'(refr_cnt), 64'd2);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cen       = ($urandom_range(0, 2) != 0);
         sync      = ($urandom_range(0, 39) == 0);
         rst       = ($urandom_range(0, 499) == 0);
         if (dl) dl = ($urandom_range(0, 3) != 0);
         else    dl = ($urandom_range(0, 399) == 0);
         data_read = 16'($urandom);
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 15) == 0)
               ch_addr[c*KW +: KW] = ($urandom_range(0, 1) != 0) ? 23'($urandom_range(0, 7))
                                                                 : 23'($urandom);
         step();
      end
      rst = 0; dl = 0; cen = 0;
      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtgng_rom_sched.md
# jtgng_rom_sched

Parametrised SDRAM ROM read scheduler: time-multiplexes one SDRAM read port among `CH` ROM clients using a programmable slot table. It also inserts auto-refresh slots and reports per-channel data validity. It sits between the per-subsystem ROM address buses (CPU, sound, char, obj, scroll) and the SDRAM controller, and supersedes fixed 16-slot ROM sequencers. It adds configurable channel count, per-channel byte/word mode, per-channel offsets and a data-valid (`ok`) flag.

## Interface
- `CH`, 4, number of client channels (1..14)
- `AW`, 22, SDRAM word-address width
- `LAT`, 1, cen cycles from address issue to data capture (1..4)
- `OFFSETS`, 0, CH×AW packed word offsets; channel c uses bits [c*AW +: AW]
- `BYTE_MASK`, 0, CH bits; bit c=1 makes channel c byte-wide
- `SLOT_MAP`, 64'hE000_0000_3210_3210, 16×4 packed slot table; entry s is bits [s*4 +: 4]. Values: 0..CH-1 = channel, 4'hE = refresh, anything else = idle
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `cen` in 1: slot-advance clock enable (12 MHz in current cores)
- `sync` in 1: realigns the slot counter to 0 (driven from H==0 && Hsub==0)
- `downloading` in 1: ROM download in progress; holds block idle
- `ch_addr` in CH×(AW+1): per-channel address. Word channels: [AW-1:0] word address, MSB ignored. Byte channels: [AW:1] word address, bit 0 byte select
- `ch_dout` out CH×16: per-channel read data
- `ch_ok` out CH: data in `ch_dout` matches current `ch_addr`
- `ready` out 1: scheduler running and pipeline primed
- `autorefresh` out 1: request refresh to SDRAM controller
- `sdram_addr` out AW: read address to SDRAM
- `data_read` in 16: SDRAM read data

## Operation
- Slot counter `slot[3:0]` advances +1 on each `cen` and wraps 15→0. `sync` with `cen` loads 0 instead. `sync` without `cen` has no effect.
- On each `cen`, take entry e = SLOT_MAP[slot]:
  - Channel: `sdram_addr` ← OFFSETS[e] + word address of channel e, modulo 2^AW. Push {valid=1, ch=e, lsb, requested addr} into a LAT-deep pipeline.
  - Refresh: `autorefresh` ← 1, push valid=0, `sdram_addr` holds.
  - Idle: push valid=0, `autorefresh` ← 0.
  - `autorefresh` is 0 in every non-refresh slot.
- On each `cen`, the pipeline output entry, if valid, captures `data_read` into channel ch:
  - Word mode: full 16 bits.
  - Byte mode: {8'd0, lsb ? data_read[7:0] : data_read[15:8]}.
  - `ch_ok[ch]` ← (stored address == current `ch_addr[ch]`, including the byte-select bit).
- Each cycle, `ch_ok[c]` clears combinationally-registered (next clk) when `ch_addr[c]` differs from the last captured address. Capture and clear on the same clk: capture wins.
- `ready`: after `rst`/`downloading` deassert, a 4-bit shift fills with 1s on `clk`. `ready` rises on the 5th clk. It drops the clk after `rst` or `downloading` assert.
- Channels absent from SLOT_MAP keep their reset `ch_dout`/`ch_ok`.

## Timing
- Reset values (`rst` or `downloading`): `sdram_addr`=0, `autorefresh`=0, all `ch_dout`=0, all `ch_ok`=0, `ready`=0, `slot`=0, pipeline valids=0.
- Issue→capture: an address issued at cen k is captured at cen k+LAT. `ch_dout` and `ch_ok` update on the clk of cen k+LAT.
- Address change after issue but before capture: data is still written, `ch_ok` stays 0.
- `sync` mid-frame: in-flight pipeline entries complete normally; only slot numbering restarts.
- `downloading` mid-operation: pipeline flushed (no captures), outputs return to reset values the next clk.
- Worst-case refresh period: 16 cen cycles per refresh entry.

## Test plan
- Default params, ch_addr[0]=22'h00100, OFFSETS[0]=22'h0A000: `sdram_addr`=22'h0A100 at slot 0. With data_read=16'hBEEF at the next cen, `ch_dout[0]`=16'hBEEF and `ch_ok[0]`=1.
- Byte channel 1: addr bit0=1, data 16'h12_34 → `ch_dout[1]`=16'h0034. With bit0=0 → 16'h0012.
- Change ch_addr[2] one clk after issue: `ch_ok[2]`=0 after capture. Next scheduled read at the unchanged new address → `ch_ok[2]`=1.
- Free-run 32 cen: `autorefresh`=1 exactly in slots 15 (entry E), two pulses total, each one cen-period wide.
- `sync` asserted with cen at slot 9: next issue uses SLOT_MAP[0]. Slot-9 data is still captured at LAT=1.
- `rst` pulse mid-run: all outputs 0 the next clk. `ready` returns 1 five clks after release.
